// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RV32I immediate/opcode-class decoder feeding the LoadUpper
// execute unit, with a 2-entry skid buffer (SKID_EN=1) or a single entry (SKID_EN=0).
module imm_decode_stage #(
    parameter int unsigned SKID_EN = 1
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Flush,
    input  logic        i_Valid,
    output logic        o_Ready,
    input  logic [31:0] i_Instr,
    input  logic [31:0] i_PC,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [31:0] o_PC,
    output logic [31:0] o_Imm,
    output logic        o_LuOp,
    output logic        o_IsLU,
    output logic [2:0]  o_ImmType,
    output logic [4:0]  o_Rd,
    output logic        o_Illegal
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IMM_T_W  = 3;
    localparam int unsigned RD_W     = 5;

    localparam logic [IMM_T_W-1:0] IMM_NONE = 3'd0;
    localparam logic [IMM_T_W-1:0] IMM_I    = 3'd1;
    localparam logic [IMM_T_W-1:0] IMM_S    = 3'd2;
    localparam logic [IMM_T_W-1:0] IMM_B    = 3'd3;
    localparam logic [IMM_T_W-1:0] IMM_U    = 3'd4;
    localparam logic [IMM_T_W-1:0] IMM_J    = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    imm;
        logic               lu_op;
        logic               is_lu;
        logic [IMM_T_W-1:0] imm_type;
        logic [RD_W-1:0]    rd;
        logic               illegal;
    } entry_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t dec;
    logic   ready_q;
    logic   valid_q;
    logic   accept;
    logic   emit;

    // Handshake qualifiers; the non-skid variant exposes a pass-through ready.
    assign o_Ready = (SKID_EN != 0) ? ready_q : (!valid_q || i_Ready);
    assign accept  = i_Valid && o_Ready;
    assign emit    = valid_q && i_Ready;

    // Opcode classification and immediate assembly for the incoming instruction.
    always_comb begin
        dec          = '0;
        dec.pc       = i_PC;
        dec.rd       = i_Instr[11:7];
        case (i_Instr[6:0])
            7'b0110111: begin
                dec.imm_type = IMM_U;
                dec.is_lu    = 1'b1;
            end
            7'b0010111: begin
                dec.imm_type = IMM_U;
                dec.is_lu    = 1'b1;
                dec.lu_op    = 1'b1;
            end
            7'b1101111: dec.imm_type = IMM_J;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b1110011, 7'b0001111: dec.imm_type = IMM_I;
            7'b0100011: begin
                dec.imm_type = IMM_S;
                dec.rd       = '0;
            end
            7'b1100011: begin
                dec.imm_type = IMM_B;
                dec.rd       = '0;
            end
            7'b0110011: dec.imm_type = IMM_NONE;
            default: begin
                dec.illegal = 1'b1;
                dec.rd      = '0;
            end
        endcase
        case (dec.imm_type)
            IMM_I:   dec.imm = {{20{i_Instr[31]}}, i_Instr[31:20]};
            IMM_S:   dec.imm = {{20{i_Instr[31]}}, i_Instr[31:25], i_Instr[11:7]};
            IMM_B:   dec.imm = {{19{i_Instr[31]}}, i_Instr[31], i_Instr[7],
                                i_Instr[30:25], i_Instr[11:8], 1'b0};
            IMM_U:   dec.imm = {i_Instr[31:12], 12'b0};
            IMM_J:   dec.imm = {{11{i_Instr[31]}}, i_Instr[31], i_Instr[19:12],
                                i_Instr[20], i_Instr[30:21], 1'b0};
            default: dec.imm = '0;
        endcase
    end

    // Occupancy state machine: main entry drives outputs, skid absorbs one extra accept.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else if (i_Flush) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        main_q  <= dec;
                        state   <= ST_ONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !emit && (SKID_EN != 0)) begin
                        skid_q  <= dec;
                        state   <= ST_FULL;
                        ready_q <= 1'b0;
                    end else if (accept) begin
                        main_q  <= dec;
                        ready_q <= 1'b1;
                    end else if (emit) begin
                        state   <= ST_EMPTY;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        main_q  <= skid_q;
                        state   <= ST_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Outputs come straight from the main entry register.
    assign o_Valid   = valid_q;
    assign o_PC      = main_q.pc;
    assign o_Imm     = main_q.imm;
    assign o_LuOp    = main_q.lu_op;
    assign o_IsLU    = main_q.is_lu;
    assign o_ImmType = main_q.imm_type;
    assign o_Rd      = main_q.rd;
    assign o_Illegal = main_q.illegal;

endmodule
